// File: rtl/stage_e_md.sv
// Execute-stage multiply/divide unit holding architectural HI/LO.
// Optional madd/maddu/msub/msubu support is enabled by defining STAGE_E_MD_MADD_EN.
module stage_e_md #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [3:0]  MD_Op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        IntReq,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
   localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef STAGE_E_MD_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t             state, state_nxt;
   logic        [4:0]  count, count_nxt;
   logic        [3:0]  op_p0;
   logic        [31:0] a_p0, b_p0;
   logic        [31:0] hi_nxt, lo_nxt;
   logic               latch, accept, is_mult, is_div;
   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;

   // Signed divide via magnitudes: quotient truncates toward zero, remainder
   // follows the dividend; 0x80000000 / -1 falls out as 0x80000000 rem 0.
   function automatic logic [63:0] div_signed(input logic [31:0] n, input logic [31:0] d);
      logic [31:0] mn, md, q, r;
      mn = n[31] ? -n : n;
      md = d[31] ? -d : d;
      q  = (md == 32'd0) ? 32'd0 : mn / md;
      r  = (md == 32'd0) ? 32'd0 : mn % md;
      if (n[31] ^ d[31]) q = -q;
      if (n[31]) r = -r;
      return {r, q};
   endfunction

   function automatic logic [63:0] div_unsigned(input logic [31:0] n, input logic [31:0] d);
      logic [31:0] q, r;
      q = (d == 32'd0) ? 32'd0 : n / d;
      r = (d == 32'd0) ? 32'd0 : n % d;
      return {r, q};
   endfunction

   assign Busy   = (state == BUSY);
   assign accept = Start & ~IntReq & ~Busy & (MD_Op != 4'd0);

   always_comb begin
      is_mult = (MD_Op == OP_MULT) || (MD_Op == OP_MULTU);
`ifdef STAGE_E_MD_MADD_EN
      is_mult = is_mult || (MD_Op >= OP_MADD && MD_Op <= OP_MSUBU);
`endif
      is_div  = (MD_Op == OP_DIV) || (MD_Op == OP_DIVU);
   end

   always_comb begin
      prod_s = $signed({{32{a_p0[31]}}, a_p0}) * $signed({{32{b_p0[31]}}, b_p0});
      prod_u = {32'd0, a_p0} * {32'd0, b_p0};
   end

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      hi_nxt    = HI;
      lo_nxt    = LO;
      latch     = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (MD_Op == OP_MTHI) begin
                  hi_nxt = A;
               end else if (MD_Op == OP_MTLO) begin
                  lo_nxt = A;
               end else if (is_mult) begin
                  state_nxt = BUSY;
                  count_nxt = MULT_N;
                  latch     = 1'b1;
               end else if (is_div) begin
                  state_nxt = BUSY;
                  count_nxt = DIV_N;
                  latch     = 1'b1;
               end
            end
         end
         BUSY: begin
            count_nxt = count - 5'd1;
            if (count <= 5'd1) begin
               state_nxt = IDLE;
               count_nxt = 5'd0;
               // Results come from the latched operands; accumulate ops use HI/LO as of now.
               case (op_p0)
                  OP_MULT:  {hi_nxt, lo_nxt} = prod_s;
                  OP_MULTU: {hi_nxt, lo_nxt} = prod_u;
                  OP_DIV:   if (b_p0 != 32'd0) {hi_nxt, lo_nxt} = div_signed(a_p0, b_p0);
                  OP_DIVU:  if (b_p0 != 32'd0) {hi_nxt, lo_nxt} = div_unsigned(a_p0, b_p0);
`ifdef STAGE_E_MD_MADD_EN
                  OP_MADD:  {hi_nxt, lo_nxt} = {HI, LO} + prod_s;
                  OP_MADDU: {hi_nxt, lo_nxt} = {HI, LO} + prod_u;
                  OP_MSUB:  {hi_nxt, lo_nxt} = {HI, LO} - prod_s;
                  OP_MSUBU: {hi_nxt, lo_nxt} = {HI, LO} - prod_u;
`endif
                  default: ;
               endcase
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         count <= 5'd0;
         HI    <= 32'd0;
         LO    <= 32'd0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         HI    <= hi_nxt;
         LO    <= lo_nxt;
      end
   end

   // Operand capture stage
   always_ff @(posedge clk) begin
      if (latch) begin
         op_p0 <= MD_Op;
         a_p0  <= A;
         b_p0  <= B;
      end
   end

endmodule

// File: tb/tb_stage_e_md.sv
// Self-checking bench for stage_e_md: directed cases plus random traffic
// compared each cycle against a behavioural HI/LO model.
module tb_stage_e_md;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        Start;
   logic [3:0]  MD_Op;
   logic [31:0] A, B;
   logic        IntReq;
   logic        Busy;
   logic [31:0] HI, LO;

   int n_vec = 0;
   int n_err = 0;
   int n_hazard = 0;

   // model state
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_a = 32'd0, m_b = 32'd0;
   logic [3:0]  m_op = 4'd0;
   int          m_cnt = 0;

   always #5 clk = ~clk;

   stage_e_md #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .Start(Start), .MD_Op(MD_Op), .A(A), .B(B),
      .IntReq(IntReq), .Busy(Busy), .HI(HI), .LO(LO)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic finish_op();
      longint          sa, sb, q, r;
      longint unsigned ua, ub;
      logic [63:0]     acc;
      sa  = $signed(m_a);
      sb  = $signed(m_b);
      ua  = m_a;
      ub  = m_b;
      acc = {m_hi, m_lo};
      case (m_op)
         4'd1: acc = sa * sb;
         4'd2: acc = ua * ub;
         4'd3: if (m_b != 0) begin
            q   = sa / sb;
            r   = sa % sb;
            acc = {r[31:0], q[31:0]};
         end
         4'd4: if (m_b != 0) acc = {m_a % m_b, m_a / m_b};
`ifdef STAGE_E_MD_MADD_EN
         4'd7:  acc = acc + sa * sb;
         4'd8:  acc = acc + ua * ub;
         4'd9:  acc = acc - sa * sb;
         4'd10: acc = acc - ua * ub;
`endif
         default: ;
      endcase
      {m_hi, m_lo} = acc;
   endtask

   task automatic model_edge(input logic s, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic irq, input logic rst);
      int lat;
      lat = 0;
      if (!rst) begin
         m_hi = 0; m_lo = 0; m_cnt = 0;
      end else if (m_cnt > 0) begin
         if (s) n_hazard++;
         m_cnt--;
         if (m_cnt == 0) finish_op();
      end else if (s && !irq) begin
         case (op)
            4'd5: m_hi = a;
            4'd6: m_lo = a;
            4'd1, 4'd2: lat = MC;
            4'd3, 4'd4: lat = DC;
`ifdef STAGE_E_MD_MADD_EN
            4'd7, 4'd8, 4'd9, 4'd10: lat = MC;
`endif
            default: ;
         endcase
         if (lat > 0) begin
            m_cnt = lat; m_op = op; m_a = a; m_b = b;
         end
      end
   endtask

   task automatic step(input logic s, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic irq, input logic rst);
      Start = s; MD_Op = op; A = a; B = b; IntReq = irq; reset = rst;
      model_edge(s, op, a, b, irq, rst);
      @(negedge clk);
      chk("busy", 64'(Busy), 64'(m_cnt != 0));
      chk("hi", 64'(HI), 64'(m_hi));
      chk("lo", 64'(LO), 64'(m_lo));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
   endtask

   task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int n);
      int seen;
      seen = 0;
      step(1'b1, op, a, b, 1'b0, 1'b1);
      for (int i = 0; i < n; i++) begin
         seen += int'(Busy);
         idle(1);
      end
      chk({tag, "_busy_len"}, 64'(seen), 64'(n));
      chk({tag, "_busy_fall"}, 64'(Busy), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] edges [5];
      logic [31:0] ra, rb;
      logic [3:0]  rop;
      edges[0] = 32'h0; edges[1] = 32'h1; edges[2] = 32'hFFFFFFFF;
      edges[3] = 32'h80000000; edges[4] = 32'h7FFFFFFF;

      step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      step(1'b1, 4'd1, 32'd3, 32'd4, 1'b0, 1'b0);
      chk("rst_busy", 64'(Busy), 64'd0);
      chk("rst_hi", 64'(HI), 64'd0);
      chk("rst_lo", 64'(LO), 64'd0);

      run_md("mult", 4'd1, 32'hFFFFFFFE, 32'd3, MC);
      chk("mult_hi", 64'(HI), 64'hFFFFFFFF);
      chk("mult_lo", 64'(LO), 64'hFFFFFFFA);

      run_md("multu", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, MC);
      chk("multu_hi", 64'(HI), 64'hFFFFFFFE);
      chk("multu_lo", 64'(LO), 64'h00000001);

      run_md("div", 4'd3, 32'hFFFFFFF9, 32'd2, DC);
      chk("div_lo", 64'(LO), 64'hFFFFFFFD);
      chk("div_hi", 64'(HI), 64'hFFFFFFFF);

      run_md("divu0", 4'd4, 32'd7, 32'd0, DC);
      chk("divu0_lo", 64'(LO), 64'hFFFFFFFD);
      chk("divu0_hi", 64'(HI), 64'hFFFFFFFF);

      run_md("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, DC);
      chk("divovf_lo", 64'(LO), 64'h80000000);
      chk("divovf_hi", 64'(HI), 64'h0);

      step(1'b1, 4'd5, 32'h12345678, 32'd0, 1'b0, 1'b1);
      chk("mthi_hi", 64'(HI), 64'h12345678);
      step(1'b1, 4'd6, 32'h9ABCDEF0, 32'd0, 1'b0, 1'b1);
      chk("mtlo_lo", 64'(LO), 64'h9ABCDEF0);
      chk("mtlo_busy", 64'(Busy), 64'd0);

      step(1'b1, 4'd1, 32'd7, 32'd9, 1'b1, 1'b1);
      idle(MC + 1);
      chk("irq_drop_hi", 64'(HI), 64'h12345678);
      chk("irq_drop_lo", 64'(LO), 64'h9ABCDEF0);

      step(1'b1, 4'd1, 32'd7, 32'd9, 1'b0, 1'b1);
      step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b1);
      idle(MC - 2);
      chk("irq_busy_lo", 64'(LO), 64'd63);
      chk("irq_busy_hi", 64'(HI), 64'd0);

      step(1'b1, 4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1);
      idle(2);
      step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      chk("midrst_busy", 64'(Busy), 64'd0);
      chk("midrst_hi", 64'(HI), 64'd0);
      chk("midrst_lo", 64'(LO), 64'd0);
      idle(DC);
      chk("midrst_stay", 64'({HI, LO}), 64'd0);

`ifdef STAGE_E_MD_MADD_EN
      step(1'b1, 4'd6, 32'd5, 32'd0, 1'b0, 1'b1);
      step(1'b1, 4'd5, 32'd0, 32'd0, 1'b0, 1'b1);
      run_md("madd", 4'd7, 32'd2, 32'd3, MC);
      chk("madd_hi", 64'(HI), 64'd0);
      chk("madd_lo", 64'(LO), 64'd11);
`endif

      for (int i = 0; i < 400; i++) begin
         rop = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 6)) : 4'($urandom_range(0, 15));
         ra  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
         if ($urandom_range(0, 7) == 0) rb = 32'd0;
         step(1'($urandom_range(0, 2) == 0), rop, ra, rb,
              1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 63) != 0));
      end

      $display("note: %0d Start pulses issued while busy (hazard-unit error) were ignored", n_hazard);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
